// File: rtl/modulo_envase_vedacao_param.sv
// Bottle filling and sealing controller with cork stock register,
// automatic refill and batch counters.
//
// state      | meaning
// -----------+----------------------------------------------
// PARADO     | stopped, all actuators off
// TRANSPORTE | conveyor running, waiting for bottle in position
// ENCHIMENTO | fill valve open, waiting for bottle full
// VEDACAO    | sealer active, waiting for sealing complete
// ALARME     | no corks available, waiting for stock
module modulo_envase_vedacao_param #(
    parameter int W_ROLHAS   = 7,
    parameter int MAX_ROLHAS = 99,
    parameter int MIN_ROLHAS = 5,
    parameter int REFILL     = 20,
    parameter int LOTE       = 12,
    parameter int W_LOTES    = 4,
    parameter int MAX_LOTES  = 10
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                enable,
    input  logic                pg,
    input  logic                ch,
    input  logic                cq,
    input  logic                op_add,
    input  logic                dispensador,
    output logic                m,
    output logic                ev,
    output logic                ve,
    output logic                al,
    output logic [2:0]          estado,
    output logic [W_ROLHAS-1:0] rolhas,
    output logic [3:0]          garrafas,
    output logic [W_LOTES-1:0]  lotes,
    output logic                lote_ok,
    output logic                rolha_baixa
);

    typedef enum logic [2:0] {
        PARADO     = 3'd0,
        TRANSPORTE = 3'd1,
        ENCHIMENTO = 3'd2,
        VEDACAO    = 3'd3,
        ALARME     = 3'd4
    } state_t;

    // The stock sum carries one extra bit so refill plus operator add
    // cannot wrap before the saturation compare.
    localparam int SW = W_ROLHAS + 1;
    localparam logic [SW-1:0]       REFILL_S  = SW'(REFILL);
    localparam logic [SW-1:0]       MAX_S     = SW'(MAX_ROLHAS);
    localparam logic [W_ROLHAS-1:0] MIN_R     = W_ROLHAS'(MIN_ROLHAS);
    localparam logic [3:0]          LOTE_LAST = 4'(LOTE - 1);
    localparam logic [W_LOTES-1:0]  LOTES_LAST = W_LOTES'(MAX_LOTES - 1);

    state_t        state, state_nx;
    logic          enable_q;
    logic          rise;
    logic          consume;
    logic          auto_refill;
    logic [SW-1:0] soma;

    // State register
    always_ff @(posedge clk) begin
        if (clr) state <= PARADO;
        else     state <= state_nx;
    end

    // Next-state decode; enable low overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            PARADO:     if (enable) state_nx = TRANSPORTE;
            TRANSPORTE: if (pg) state_nx = ENCHIMENTO;
            ENCHIMENTO: if (ch) state_nx = (rolhas != '0) ? VEDACAO : ALARME;
            VEDACAO:    if (cq) state_nx = TRANSPORTE;
            ALARME:     if (rolhas != '0) state_nx = VEDACAO;
            default:    state_nx = PARADO;
        endcase
        if (!enable) state_nx = PARADO;
    end

    // Moore actuator decode from the registered state
    always_comb begin
        m  = 1'b0;
        ev = 1'b0;
        ve = 1'b0;
        al = 1'b0;
        case (state)
            TRANSPORTE: m  = 1'b1;
            ENCHIMENTO: ev = 1'b1;
            VEDACAO:    ve = 1'b1;
            ALARME:     al = 1'b1;
            default:    ;
        endcase
    end

    // Stock arithmetic: all events of a cycle summed together, then saturated
    always_comb begin
        consume     = (state == VEDACAO) && cq;
        auto_refill = dispensador && (rolhas < MIN_R);
        rise        = enable && !enable_q;
        soma        = {1'b0, rolhas} + SW'(op_add)
                    + (auto_refill ? REFILL_S : '0) - SW'(consume);
    end

    // Cork stock register and enable edge detector
    always_ff @(posedge clk) begin
        if (clr) begin
            rolhas   <= '0;
            enable_q <= 1'b0;
        end else begin
            rolhas   <= (soma > MAX_S) ? MAX_S[W_ROLHAS-1:0] : soma[W_ROLHAS-1:0];
            enable_q <= enable;
        end
    end

    // Bottle and batch counters; a new run (enable rising) starts from zero
    always_ff @(posedge clk) begin
        if (clr) begin
            garrafas <= '0;
            lotes    <= '0;
            lote_ok  <= 1'b0;
        end else if (rise) begin
            garrafas <= '0;
            lotes    <= '0;
            lote_ok  <= 1'b0;
        end else begin
            lote_ok <= 1'b0;
            if (consume) begin
                if (garrafas == LOTE_LAST) begin
                    garrafas <= '0;
                    lotes    <= (lotes == LOTES_LAST) ? '0 : lotes + 1'b1;
                    lote_ok  <= 1'b1;
                end else begin
                    garrafas <= garrafas + 1'b1;
                end
            end
        end
    end

    assign estado      = state;
    assign rolha_baixa = (rolhas < MIN_R);

endmodule

// File: tb/tb_modulo_envase_vedacao_param.sv
// Directed bench for modulo_envase_vedacao_param with default generics.
module tb_modulo_envase_vedacao_param;

    logic       clk = 1'b0;
    logic       clr, enable, pg, ch, cq, op_add, dispensador;
    logic       m, ev, ve, al, lote_ok, rolha_baixa;
    logic [2:0] estado;
    logic [6:0] rolhas;
    logic [3:0] garrafas;
    logic [3:0] lotes;

    int errors = 0;
    int checks = 0;

    modulo_envase_vedacao_param dut (
        .clk(clk), .clr(clr), .enable(enable), .pg(pg), .ch(ch), .cq(cq),
        .op_add(op_add), .dispensador(dispensador),
        .m(m), .ev(ev), .ve(ve), .al(al), .estado(estado), .rolhas(rolhas),
        .garrafas(garrafas), .lotes(lotes), .lote_ok(lote_ok),
        .rolha_baixa(rolha_baixa)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seal();
        pg = 1'b1; step(); pg = 1'b0;
        ch = 1'b1; step(); ch = 1'b0;
        cq = 1'b1; step(); cq = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; enable = 1'b0; pg = 1'b0; ch = 1'b0; cq = 1'b0;
        op_add = 1'b0; dispensador = 1'b0;
        step(); step();
        clr = 1'b0;
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        checks++; if ({m, ev, ve, al} !== 4'b0000) begin errors++; $display("FAIL reset_act got=%b exp=0000", {m, ev, ve, al}); end
        checks++; if (rolhas !== 7'd0) begin errors++; $display("FAIL reset_rolhas got=%0d exp=0", rolhas); end
        checks++; if (garrafas !== 4'd0 || lotes !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", garrafas, lotes); end
        checks++; if (lote_ok !== 1'b0) begin errors++; $display("FAIL reset_lote_ok got=%b exp=0", lote_ok); end
        checks++; if (rolha_baixa !== 1'b1) begin errors++; $display("FAIL reset_rolha_baixa got=%b exp=1", rolha_baixa); end
    endtask

    task automatic test_op_add();
        op_add = 1'b1; repeat (3) step(); op_add = 1'b0;
        checks++; if (rolhas !== 7'd3) begin errors++; $display("FAIL op_add_rolhas got=%0d exp=3", rolhas); end
        checks++; if (estado !== 3'd0 || {m, ev, ve, al} !== 4'b0000) begin errors++; $display("FAIL op_add_idle got=%0d/%b exp=0/0000", estado, {m, ev, ve, al}); end
    endtask

    task automatic test_seal_cycle();
        enable = 1'b1; step();
        checks++; if (estado !== 3'd1 || m !== 1'b1) begin errors++; $display("FAIL seq_transporte got=%0d m=%b exp=1 m=1", estado, m); end
        pg = 1'b1; step(); pg = 1'b0;
        checks++; if (estado !== 3'd2 || ev !== 1'b1 || m !== 1'b0) begin errors++; $display("FAIL seq_enchimento got=%0d ev=%b exp=2 ev=1", estado, ev); end
        ch = 1'b1; step(); ch = 1'b0;
        checks++; if (estado !== 3'd3 || ve !== 1'b1) begin errors++; $display("FAIL seq_vedacao got=%0d ve=%b exp=3 ve=1", estado, ve); end
        cq = 1'b1; step(); cq = 1'b0;
        checks++; if (estado !== 3'd1 || m !== 1'b1 || ve !== 1'b0) begin errors++; $display("FAIL seq_back got=%0d exp=1", estado); end
        checks++; if (rolhas !== 7'd2 || garrafas !== 4'd1) begin errors++; $display("FAIL seq_consume got=%0d/%0d exp=2/1", rolhas, garrafas); end
    endtask

    task automatic test_alarm();
        seal(); seal();
        checks++; if (rolhas !== 7'd0 || garrafas !== 4'd3) begin errors++; $display("FAIL alarm_pre got=%0d/%0d exp=0/3", rolhas, garrafas); end
        pg = 1'b1; step(); pg = 1'b0;
        ch = 1'b1; step(); ch = 1'b0;
        checks++; if (estado !== 3'd4 || al !== 1'b1 || ve !== 1'b0) begin errors++; $display("FAIL alarm_enter got=%0d al=%b exp=4 al=1", estado, al); end
        op_add = 1'b1; step(); op_add = 1'b0;
        checks++; if (estado !== 3'd4 || rolhas !== 7'd1) begin errors++; $display("FAIL alarm_add got=%0d/%0d exp=4/1", estado, rolhas); end
        step();
        checks++; if (estado !== 3'd3 || ve !== 1'b1 || al !== 1'b0) begin errors++; $display("FAIL alarm_exit got=%0d exp=3", estado); end
        cq = 1'b1; step(); cq = 1'b0;
        checks++; if (estado !== 3'd1 || rolhas !== 7'd0 || garrafas !== 4'd4) begin errors++; $display("FAIL alarm_seal got=%0d/%0d/%0d exp=1/0/4", estado, rolhas, garrafas); end
    endtask

    task automatic test_simultaneous();
        op_add = 1'b1; repeat (4) step(); op_add = 1'b0;
        checks++; if (rolhas !== 7'd4 || rolha_baixa !== 1'b1) begin errors++; $display("FAIL simul_pre got=%0d low=%b exp=4 low=1", rolhas, rolha_baixa); end
        pg = 1'b1; step(); pg = 1'b0;
        ch = 1'b1; step(); ch = 1'b0;
        dispensador = 1'b1; op_add = 1'b1; cq = 1'b1; step();
        dispensador = 1'b0; op_add = 1'b0; cq = 1'b0;
        checks++; if (rolhas !== 7'd24) begin errors++; $display("FAIL simul_sum got=%0d exp=24", rolhas); end
        checks++; if (estado !== 3'd1 || garrafas !== 4'd5) begin errors++; $display("FAIL simul_state got=%0d/%0d exp=1/5", estado, garrafas); end
    endtask

    task automatic test_saturation();
        op_add = 1'b1; repeat (71) step(); op_add = 1'b0;
        checks++; if (rolhas !== 7'd95) begin errors++; $display("FAIL sat_pre got=%0d exp=95", rolhas); end
        dispensador = 1'b1; step(); dispensador = 1'b0;
        checks++; if (rolhas !== 7'd95) begin errors++; $display("FAIL sat_no_auto got=%0d exp=95", rolhas); end
        op_add = 1'b1; repeat (5) step(); op_add = 1'b0;
        checks++; if (rolhas !== 7'd99 || rolha_baixa !== 1'b0) begin errors++; $display("FAIL sat_ceiling got=%0d low=%b exp=99 low=0", rolhas, rolha_baixa); end
    endtask

    task automatic test_batch();
        int pulses;
        pulses = 0;
        enable = 1'b0; step();
        checks++; if (estado !== 3'd0 || m !== 1'b0 || garrafas !== 4'd5) begin errors++; $display("FAIL stop_hold got=%0d/%0d exp=0/5", estado, garrafas); end
        enable = 1'b1; step();
        checks++; if (estado !== 3'd1 || garrafas !== 4'd0 || lotes !== 4'd0) begin errors++; $display("FAIL restart_clear got=%0d/%0d/%0d exp=1/0/0", estado, garrafas, lotes); end
        dispensador = 1'b1;
        for (int k = 0; k < 120; k++) begin
            pg = 1'b1; step(); pg = 1'b0;
            checks++; if (lote_ok !== 1'b0) begin errors++; $display("FAIL batch_pulse_width k=%0d got=%b exp=0", k, lote_ok); end
            ch = 1'b1; step(); ch = 1'b0;
            cq = 1'b1; step(); cq = 1'b0;
            if (lote_ok === 1'b1) pulses++;
            checks++;
            if (lote_ok !== ((k % 12) == 11) || garrafas !== 4'((k + 1) % 12) ||
                lotes !== 4'(((k + 1) / 12) % 10) || estado !== 3'd1) begin
                errors++;
                $display("FAIL batch k=%0d got ok=%b g=%0d l=%0d st=%0d exp ok=%b g=%0d l=%0d st=1",
                         k, lote_ok, garrafas, lotes, estado, ((k % 12) == 11),
                         (k + 1) % 12, ((k + 1) / 12) % 10);
            end
        end
        checks++; if (pulses !== 10 || lotes !== 4'd0) begin errors++; $display("FAIL batch_wrap got pulses=%0d l=%0d exp 10/0", pulses, lotes); end
    endtask

    task automatic test_clr();
        seal();
        checks++; if (garrafas !== 4'd1) begin errors++; $display("FAIL clr_pre got=%0d exp=1", garrafas); end
        pg = 1'b1; step(); pg = 1'b0;
        ch = 1'b1; step(); ch = 1'b0;
        checks++; if (estado !== 3'd3 || rolhas === 7'd0) begin errors++; $display("FAIL clr_vedacao got=%0d/%0d exp=3/nonzero", estado, rolhas); end
        cq = 1'b1; clr = 1'b1; step(); cq = 1'b0; clr = 1'b0;
        checks++; if (estado !== 3'd0 || {m, ev, ve, al} !== 4'b0000) begin errors++; $display("FAIL clr_state got=%0d/%b exp=0/0000", estado, {m, ev, ve, al}); end
        checks++; if (rolhas !== 7'd0 || garrafas !== 4'd0 || lotes !== 4'd0 || lote_ok !== 1'b0) begin errors++; $display("FAIL clr_regs got=%0d/%0d/%0d/%b exp=0/0/0/0", rolhas, garrafas, lotes, lote_ok); end
    endtask

    initial begin
        test_reset();
        test_op_add();
        test_seal_cycle();
        test_alarm();
        test_simultaneous();
        test_saturation();
        test_batch();
        test_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
